// File: rtl/freq_scan_controller_if.sv
// AXI4-Lite link between the scan controller (master) and the frequency meter bank (slave).
`timescale 1ns/1ps
interface freq_scan_controller_if;
  logic [15:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [15:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/freq_scan_controller.sv
// Walks a bank of frequency meters over AXI4-Lite: program gate select, flush the stale
// result, wait for a second fresh result, then present it on the res_* outputs.
`timescale 1ns/1ps
module freq_scan_controller #(
  parameter int unsigned NUM_CH         = 4,
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int unsigned POLL_GAP       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**24,
  localparam int unsigned CH_W          = $clog2(NUM_CH)
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            start,
  input  logic            continuous,
  input  logic [2:0]      gate_sel,
  output logic            busy,
  output logic            done,
  output logic            res_valid,
  output logic [CH_W-1:0] res_ch,
  output logic [15:0]     res_cnt,
  output logic            res_ovf,
  output logic            res_err,
  freq_scan_controller_if.master m
);

  localparam logic [31:0]     TmoLimit = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     GapLast  = 32'(POLL_GAP - 1);
  localparam logic [CH_W-1:0] ChLast   = CH_W'(NUM_CH - 1);

  typedef enum logic [3:0] {
    StIdle, StSelW, StSelB, StClrAr, StClrR, StGap, StPollAr, StPollR, StEmit
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [2:0]      gsel_q, gsel_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            fresh_q, fresh_d;
  logic            err_q, err_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [31:0]     gap_q, gap_d;
  logic [CH_W-1:0] res_ch_q, res_ch_d;
  logic [15:0]     res_cnt_q, res_cnt_d;
  logic            res_ovf_q, res_ovf_d;
  logic            res_err_q, res_err_d;
  logic            done_q, done_d;
  logic [15:0]     ch_base;
  logic            unused_rdata;

  assign ch_base = BASE_ADDR + 16'({ch_q, 12'h000});

  // Address/data are forced to zero outside their valid phase so idle outputs read as 0.
  assign m.awvalid = (state_q == StSelW) && !aw_done_q;
  assign m.awaddr  = m.awvalid ? ch_base + 16'h0004 : 16'h0000;
  assign m.wvalid  = (state_q == StSelW) && !w_done_q;
  assign m.wdata   = m.wvalid ? {29'b0, gsel_q} : 32'h0;
  assign m.wstrb   = m.wvalid ? 4'hF : 4'h0;
  assign m.bready  = (state_q == StSelB);
  assign m.arvalid = (state_q == StClrAr) || (state_q == StPollAr);
  assign m.araddr  = m.arvalid ? ch_base + 16'h0008 : 16'h0000;
  assign m.rready  = (state_q == StClrR) || (state_q == StPollR);

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign res_valid = (state_q == StEmit);
  assign res_ch    = res_ch_q;
  assign res_cnt   = res_cnt_q;
  assign res_ovf   = res_ovf_q;
  assign res_err   = res_err_q;

  assign unused_rdata = ^m.rdata[31:18];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    gsel_d    = gsel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    fresh_d   = fresh_q;
    err_d     = err_q;
    gap_d     = gap_q;
    res_ch_d  = res_ch_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    res_err_d = res_err_q;
    done_d    = 1'b0;
    tmo_d     = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSelW;
          ch_d    = '0;
          gsel_d  = gate_sel;
          err_d   = 1'b0;
          fresh_d = 1'b0;
        end
      end
      StSelW: begin
        if (m.awvalid && m.awready) aw_done_d = 1'b1;
        if (m.wvalid && m.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StSelB;
        end
      end
      StSelB: begin
        if (m.bvalid) begin
          if (m.bresp != 2'b00) err_d = 1'b1;
          tmo_d   = '0;
          state_d = StClrAr;
        end
      end
      StClrAr: begin
        if (m.arready) state_d = StClrR;
      end
      StClrR: begin
        if (m.rvalid) begin
          if (m.rresp != 2'b00) err_d = 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q + 32'd1;
        // Only here is the bus idle, so abandoning the channel leaves nothing outstanding.
        if (tmo_q >= TmoLimit) begin
          res_ch_d  = ch_q;
          res_cnt_d = 16'h0000;
          res_ovf_d = 1'b0;
          res_err_d = 1'b1;
          state_d   = StEmit;
        end else if (gap_q >= GapLast) begin
          state_d = StPollAr;
        end
      end
      StPollAr: begin
        if (m.arready) state_d = StPollR;
      end
      StPollR: begin
        if (m.rvalid) begin
          if (m.rresp != 2'b00) err_d = 1'b1;
          gap_d = '0;
          if (!m.rdata[17]) begin
            state_d = StGap;
          end else if (!fresh_q) begin
            // First fresh window may have started under the old gate select.
            fresh_d = 1'b1;
            state_d = StGap;
          end else begin
            res_ch_d  = ch_q;
            res_cnt_d = m.rdata[15:0];
            res_ovf_d = m.rdata[16];
            res_err_d = err_q || (m.rresp != 2'b00);
            state_d   = StEmit;
          end
        end
      end
      StEmit: begin
        err_d   = 1'b0;
        fresh_d = 1'b0;
        if (ch_q != ChLast) begin
          ch_d    = ch_q + CH_W'(1);
          state_d = StSelW;
        end else if (continuous) begin
          ch_d    = '0;
          state_d = StSelW;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      gsel_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      fresh_q   <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      gap_q     <= '0;
      res_ch_q  <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
      res_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      gsel_q    <= gsel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      fresh_q   <= fresh_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      res_ch_q  <= res_ch_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
      res_err_q <= res_err_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_freq_scan_controller.sv
// Directed bench for freq_scan_controller with behavioural meter slaves on the AXI4-Lite link.
`timescale 1ns/1ps
module tb_freq_scan_controller;
  localparam int unsigned NumCh   = 4;
  localparam int unsigned PollGap = 4;
  localparam int unsigned Tmo     = 1000;

  logic        aclk, aresetn, start, continuous;
  logic [2:0]  gate_sel;
  logic        busy, done, res_valid, res_ovf, res_err;
  logic [1:0]  res_ch;
  logic [15:0] res_cnt;

  freq_scan_controller_if bus ();

  freq_scan_controller #(
    .NUM_CH        (NumCh),
    .BASE_ADDR     (16'h0000),
    .POLL_GAP      (PollGap),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .continuous(continuous),
    .gate_sel  (gate_sel),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_cnt   (res_cnt),
    .res_ovf   (res_ovf),
    .res_err   (res_err),
    .m         (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total, bad, cyc;
  bit stall_en, slverr0, ch2_dead, hold_r;

  // Logs, each written by exactly one process.
  logic [15:0] aw_log [128];
  logic [31:0] w_log [128];
  logic [1:0]  lg_ch [128];
  logic [15:0] lg_cnt [128];
  logic        lg_ovf [128];
  logic        lg_err [128];
  int naw, nw, nres, ndone;
  int aw_viol, w_viol, ar_viol, ovl_viol;
  int t2_start, t2_end;
  bit seen_w2;
  logic [15:0] aw_addr_q, ar_addr_q;
  int epoch [4];

  function automatic int stall_n();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(posedge aclk);
      cyc++;
    end
  end

  initial begin : aw_slave
    logic [15:0] a;
    int n;
    bus.awready = 1'b0; naw = 0; aw_viol = 0; aw_addr_q = '0;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.awvalid) begin
        a = bus.awaddr; n = stall_n();
        for (int i = 0; i < n; i++) begin
          @(negedge aclk);
          if (aresetn && !(bus.awvalid && bus.awaddr == a)) aw_viol++;
        end
        if (aresetn && bus.awvalid) begin
          bus.awready = 1'b1;
          @(posedge aclk);
          #1 bus.awready = 1'b0;
          aw_addr_q = a;
          if (naw < 128) aw_log[naw] = a;
          naw++;
        end
      end
    end
  end

  initial begin : w_slave
    logic [31:0] d;
    int n;
    bus.wready = 1'b0; nw = 0; w_viol = 0;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.wvalid) begin
        d = bus.wdata; n = stall_n();
        for (int i = 0; i < n; i++) begin
          @(negedge aclk);
          if (aresetn && !(bus.wvalid && bus.wdata == d)) w_viol++;
        end
        if (aresetn && bus.wvalid) begin
          bus.wready = 1'b1;
          @(posedge aclk);
          #1 bus.wready = 1'b0;
          if (nw < 128) w_log[nw] = d;
          nw++;
        end
      end
    end
  end

  initial begin : b_slave
    int n;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    for (int i = 0; i < 4; i++) epoch[i] = 0;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.bready) begin
        n = stall_n();
        for (int i = 0; i < n; i++) @(negedge aclk);
        if (aresetn && bus.bready) begin
          bus.bvalid = 1'b1;
          bus.bresp  = (slverr0 && aw_addr_q[13:12] == 2'd0) ? 2'b10 : 2'b00;
          epoch[aw_addr_q[13:12]]++;
          @(posedge aclk);
          #1 bus.bvalid = 1'b0;
          bus.bresp = 2'b00;
        end
      end
    end
  end

  initial begin : ar_slave
    logic [15:0] a;
    int n;
    bus.arready = 1'b0; ar_viol = 0; ar_addr_q = '0;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.arvalid) begin
        a = bus.araddr; n = stall_n();
        for (int i = 0; i < n; i++) begin
          @(negedge aclk);
          if (aresetn && !(bus.arvalid && bus.araddr == a)) ar_viol++;
        end
        if (aresetn && bus.arvalid) begin
          bus.arready = 1'b1;
          @(posedge aclk);
          #1 bus.arready = 1'b0;
          ar_addr_q = a;
        end
      end
    end
  end

  // Meter model: updated bit on every 3rd read since the last gate-select write.
  initial begin : r_slave
    int n, c;
    int rc [4];
    int fk [4];
    int last_ep [4];
    logic [31:0] data;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    for (int i = 0; i < 4; i++) begin rc[i] = 0; fk[i] = 0; last_ep[i] = 0; end
    forever begin
      @(negedge aclk);
      if (aresetn && bus.rready && !hold_r) begin
        n = stall_n();
        for (int i = 0; i < n; i++) @(negedge aclk);
        if (aresetn && bus.rready) begin
          c = int'(ar_addr_q[13:12]);
          if (last_ep[c] != epoch[c]) begin
            last_ep[c] = epoch[c]; rc[c] = 0; fk[c] = 0;
          end
          rc[c]++;
          data = '0;
          if ((rc[c] % 3 == 0) && !(ch2_dead && c == 2)) begin
            fk[c]++;
            if (c == 1) data = (fk[c] == 1) ? {14'b0, 1'b1, 1'b0, 16'hDEAD}
                                            : {14'b0, 1'b1, 1'b1, 16'h1234};
            else        data = {14'b0, 1'b1, 1'b0, 16'(c * 256 + fk[c])};
          end
          bus.rvalid = 1'b1; bus.rdata = data;
          @(posedge aclk);
          #1 bus.rvalid = 1'b0;
          bus.rdata = '0;
        end
      end
    end
  end

  initial begin : monitor
    nres = 0; ndone = 0; ovl_viol = 0; seen_w2 = 0; t2_start = 0; t2_end = 0;
    forever begin
      @(negedge aclk);
      if ((bus.awvalid || bus.wvalid || bus.bready) && (bus.arvalid || bus.rready)) ovl_viol++;
      if (bus.awvalid && bus.awaddr == 16'h2004) seen_w2 = 1'b1;
      if (seen_w2 && bus.arvalid) begin t2_start = cyc; seen_w2 = 1'b0; end
      if (res_valid) begin
        if (nres < 128) begin
          lg_ch[nres] = res_ch; lg_cnt[nres] = res_cnt;
          lg_ovf[nres] = res_ovf; lg_err[nres] = res_err;
        end
        if (res_ch == 2'd2) t2_end = cyc;
        nres++;
      end
      if (done) ndone++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int d0, k;
    d0 = ndone; k = 0;
    while (ndone == d0 && k < maxc) begin @(negedge aclk); k++; end
    check(tag, 32'(ndone - d0), 32'd1);
  endtask

  task automatic check_res(input string tag, input int idx, input int ch, input int cnt,
                           input int ovf, input int err);
    check({tag, "_ch"},  32'(lg_ch[idx]),  32'(ch));
    check({tag, "_cnt"}, 32'(lg_cnt[idx]), 32'(cnt));
    check({tag, "_ovf"}, 32'(lg_ovf[idx]), 32'(ovf));
    check({tag, "_err"}, 32'(lg_err[idx]), 32'(err));
  endtask

  task automatic check_idle_outs(input string tag);
    check(tag, {22'b0, busy, done, res_valid, res_ovf, res_err, bus.awvalid, bus.wvalid,
                bus.bready, bus.arvalid, bus.rready}, 32'h0);
    check({tag, "_res"}, {14'b0, res_ch, res_cnt}, 32'h0);
  endtask

  initial begin : main
    int base, aw0, k, lat;
    total = 0; bad = 0;
    stall_en = 0; slverr0 = 0; ch2_dead = 0; hold_r = 0;
    aresetn = 1'b0; start = 1'b0; continuous = 1'b0; gate_sel = 3'd0;
    repeat (3) @(negedge aclk);
    check_idle_outs("reset");
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Basic scan, with a start pulse while busy that must be ignored.
    gate_sel = 3'd2; base = nres; aw0 = naw;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (nres <= base && k < 3000) begin @(negedge aclk); k++; end
    check("first_emit_seen", 32'(nres > base), 32'd1);
    pulse_start();
    wait_done("p1_done", 5000);
    check("p1_nres", 32'(nres - base), 32'd4);
    check("p1_nwrites", 32'(naw - aw0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("p1_awaddr", 32'(aw_log[aw0 + i]), 32'(i * 4096 + 4));
      check("p1_wdata", w_log[aw0 + i], 32'd2);
    end
    check_res("p1_r0", base + 0, 0, 16'h0002, 0, 0);
    check_res("p1_r1", base + 1, 1, 16'h1234, 1, 0);
    check_res("p1_r2", base + 2, 2, 16'h0202, 0, 0);
    check_res("p1_r3", base + 3, 3, 16'h0302, 0, 0);
    repeat (3) @(negedge aclk);
    check("p1_idle_after", 32'(busy), 32'd0);
    check("p1_no_extra", 32'(nres - base), 32'd4);
    check("p1_hold_res_cnt", 32'(res_cnt), 32'h0302);

    // Channel 2 never updates: timeout result, channel 3 still scanned, gate_sel latched.
    ch2_dead = 1; gate_sel = 3'd5; base = nres; aw0 = naw;
    pulse_start();
    gate_sel = 3'd0;
    wait_done("p2_done", 10000);
    check("p2_nres", 32'(nres - base), 32'd4);
    check("p2_wdata_latched", w_log[aw0 + 3], 32'd5);
    check_res("p2_r0", base + 0, 0, 16'h0002, 0, 0);
    check_res("p2_r1", base + 1, 1, 16'h1234, 1, 0);
    check_res("p2_r2", base + 2, 2, 16'h0000, 0, 1);
    check_res("p2_r3", base + 3, 3, 16'h0302, 0, 0);
    lat = t2_end - t2_start;
    check("p2_tmo_latency_ok", 32'(lat >= 999 && lat <= 1000 + PollGap + 8), 32'd1);
    ch2_dead = 0;

    // Random stalls everywhere, SLVERR on channel 0's write.
    stall_en = 1; slverr0 = 1; gate_sel = 3'd2; base = nres;
    pulse_start();
    wait_done("p3_done", 20000);
    check("p3_nres", 32'(nres - base), 32'd4);
    check_res("p3_r0", base + 0, 0, 16'h0002, 0, 1);
    check_res("p3_r1", base + 1, 1, 16'h1234, 1, 0);
    check_res("p3_r2", base + 2, 2, 16'h0202, 0, 0);
    check_res("p3_r3", base + 3, 3, 16'h0302, 0, 0);
    check("p3_valid_hold_viol", 32'(aw_viol + w_viol + ar_viol), 32'd0);
    check("p3_overlap_viol", 32'(ovl_viol), 32'd0);
    stall_en = 0; slverr0 = 0;

    // Two continuous scans then stop: eight results and a single done.
    continuous = 1'b1; base = nres; k = ndone;
    pulse_start();
    lat = 0;
    while (nres < base + 5 && lat < 3000) begin @(negedge aclk); lat++; end
    check("p4_second_scan_seen", 32'(nres >= base + 5), 32'd1);
    continuous = 1'b0;
    wait_done("p4_done", 10000);
    check("p4_nres", 32'(nres - base), 32'd8);
    for (int i = 0; i < 8; i++) check("p4_ch_seq", 32'(lg_ch[base + i]), 32'(i % 4));
    repeat (100) @(negedge aclk);
    check("p4_one_done", 32'(ndone - k), 32'd1);
    check("p4_no_extra", 32'(nres - base), 32'd8);

    // Reset while channel 1 sits in a poll read.
    base = nres;
    pulse_start();
    k = 0;
    while (nres <= base && k < 3000) begin @(negedge aclk); k++; end
    while (!bus.arvalid && k < 3000) begin @(negedge aclk); k++; end
    while (!bus.rready && k < 3000) begin @(negedge aclk); k++; end
    while (bus.rready && k < 3000) begin @(negedge aclk); k++; end
    hold_r = 1;
    while (!bus.rready && k < 3000) begin @(negedge aclk); k++; end
    check("p5_in_poll_r", 32'(bus.rready && k < 3000), 32'd1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_idle_outs("p5_async_reset");
    @(posedge aclk);
    #1;
    check_idle_outs("p5_reset_edge");
    hold_r = 0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    base = nres;
    pulse_start();
    wait_done("p5_done", 5000);
    check("p5_nres", 32'(nres - base), 32'd4);
    check_res("p5_r0", base + 0, 0, 16'h0002, 0, 0);
    check_res("p5_r1", base + 1, 1, 16'h1234, 1, 0);
    check_res("p5_r3", base + 3, 3, 16'h0302, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
